// File: rtl/chunked_adder_pkg.sv
// Shared encodings for the chunked adder: operation modes and FSM states.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ADC = 2'b01,
        MODE_SUB = 2'b10,
        MODE_INC = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/chunked_adder_fast_adder.sv
// FastAdder: BITS-wide carry-lookahead adder, every carry formed directly from g/p terms.
module FastAdder #(
    parameter int unsigned BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            c_in,
    output logic [BITS-1:0] sum,
    output logic            c_out
);

    logic [BITS-1:0] g;
    logic [BITS-1:0] p;
    logic [BITS:0]   c;
    logic            c_acc;
    logic            p_acc;

    // Generate/propagate and flattened lookahead carry equations.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c_acc = 1'b0;
        p_acc = 1'b1;
        c[0]  = c_in;
        for (int i = 0; i < int'(BITS); i++) begin
            c_acc = 1'b0;
            p_acc = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c_acc = c_acc | (p_acc & g[j]);
                p_acc = p_acc & p[j];
            end
            c[i+1] = c_acc | (p_acc & c_in);
        end
        sum   = p ^ c[BITS-1:0];
        c_out = c[BITS];
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: processes WIDTH bits CHUNK at a time through one lookahead adder.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             v_out,
    output logic             z_out
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets that do not split into whole chunks.
    generate
        if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $fatal(1, "chunked_adder: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_d;
    logic               c_d, v_d, z_d;
    logic               load;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;

    FastAdder #(
        .BITS (CHUNK)
    ) u_fast_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry_q),
        .sum   (chunk_sum),
        .c_out (chunk_cout)
    );

    // Select the operand chunk addressed by the index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Next-state, operand capture and result update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_out;
        c_d     = c_out;
        v_d     = v_out;
        z_d     = z_out;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    load = 1'b1;
                end
            end
            ST_RUN: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = chunk_sum;
                    end
                end
                carry_d = chunk_cout;
                if (idx_q == IDX_W'(N - 1)) begin
                    // Carry into the MSB is recovered from the MSB sum bit.
                    c_d     = chunk_cout;
                    v_d     = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1]) ^ chunk_cout;
                    z_d     = (sum_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (start_in) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d = ST_RUN;
            a_d     = a_in;
            idx_d   = '0;
            case (mode_e'(mode_in))
                MODE_ADD: begin
                    b_d     = b_in;
                    carry_d = 1'b0;
                end
                MODE_ADC: begin
                    b_d     = b_in;
                    carry_d = c_in;
                end
                MODE_SUB: begin
                    b_d     = ~b_in;
                    carry_d = 1'b1;
                end
                MODE_INC: begin
                    b_d     = '0;
                    carry_d = 1'b1;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_out  <= '0;
            c_out    <= 1'b0;
            v_out    <= 1'b0;
            z_out    <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            sum_out  <= sum_d;
            c_out    <= c_d;
            v_out    <= v_d;
            z_out    <= z_d;
            busy_out <= (state_d == ST_RUN);
            done_out <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder at WIDTH=8, CHUNK=2 (four chunks per operation).
module tb_chunked_adder;
    import chunked_adder_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 2;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             start_in;
    logic [1:0]       mode_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             v_out;
    logic             z_out;

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    int busy_n;

    always #5 clk_in = ~clk_in;

    chunked_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (start_in),
        .mode_in  (mode_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .sum_out  (sum_out),
        .c_out    (c_out),
        .v_out    (v_out),
        .z_out    (z_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Present an operation and return just after the accepting edge.
    task automatic launch(input mode_e m, input logic [7:0] a, input logic [7:0] b, input logic ci);
        mode_in  = m;
        a_in     = a;
        b_in     = b;
        c_in     = ci;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    // Step until done_out, counting edges and busy cycles; bounded at 20 edges.
    task automatic wait_done(output int l, output int bn);
        l  = 0;
        bn = 0;
        while (!done_out && l < 20) begin
            if (busy_out) bn++;
            step();
            l++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] s, input logic c,
                                input logic v, input logic z);
        chk({tag, "_done"}, done_out, 1);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_sum"},  sum_out, s);
        chk({tag, "_c"},    c_out, c);
        chk({tag, "_v"},    v_out, v);
        chk({tag, "_z"},    z_out, z);
    endtask

    initial begin
        rst_n_in = 1'b0;
        start_in = 1'b0;
        mode_in  = 2'b00;
        a_in     = '0;
        b_in     = '0;
        c_in     = 1'b0;
        step();
        step();
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_sum",  sum_out, 0);
        chk("rst_flags", {c_out, v_out, z_out}, 0);
        rst_n_in = 1'b1;
        step();

        // ADD 0x7F + 0x01: signed overflow into 0x80
        launch(MODE_ADD, 8'h7F, 8'h01, 1'b0);
        wait_done(lat, busy_n);
        chk("add_lat", lat, 4);
        chk("add_busy_cycles", busy_n, 4);
        check_result("add", 8'h80, 1'b0, 1'b1, 1'b0);
        step();
        chk("add_pulse_end", done_out, 0);
        chk("add_idle_busy", busy_out, 0);
        chk("add_hold_sum", sum_out, 8'h80);

        // SUB 0x05 - 0x05
        launch(MODE_SUB, 8'h05, 8'h05, 1'b0);
        wait_done(lat, busy_n);
        chk("sub_lat", lat, 4);
        check_result("sub", 8'h00, 1'b1, 1'b0, 1'b1);
        step();

        // ADC 0xFF + 0x00 + 1: carry ripples through every chunk
        launch(MODE_ADC, 8'hFF, 8'h00, 1'b1);
        wait_done(lat, busy_n);
        chk("adc_lat", lat, 4);
        check_result("adc", 8'h00, 1'b1, 1'b0, 1'b1);
        step();

        // Start and operand changes during RUN are ignored
        launch(MODE_ADD, 8'h10, 8'h20, 1'b0);
        step();
        mode_in  = MODE_SUB;
        a_in     = 8'hAA;
        b_in     = 8'h55;
        c_in     = 1'b1;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        wait_done(lat, busy_n);
        chk("ign_lat", lat, 2);
        check_result("ign", 8'h30, 1'b0, 1'b0, 1'b0);
        step();
        chk("ign_no_restart_busy", busy_out, 0);
        chk("ign_no_restart_done", done_out, 0);

        // Reset two edges into RUN abandons the operation
        launch(MODE_ADD, 8'h33, 8'h11, 1'b0);
        step();
        rst_n_in = 1'b0;
        #1;
        chk("midrst_busy", busy_out, 0);
        chk("midrst_done", done_out, 0);
        chk("midrst_sum", sum_out, 0);
        chk("midrst_flags", {c_out, v_out, z_out}, 0);
        chk("midrst_state", dut.state_q, ST_IDLE);
        step();
        step();
        chk("midrst_no_done", done_out, 0);
        rst_n_in = 1'b1;
        step();
        launch(MODE_INC, 8'hFF, 8'h00, 1'b0);
        wait_done(lat, busy_n);
        chk("inc_lat", lat, 4);
        check_result("inc", 8'h00, 1'b1, 1'b0, 1'b1);
        step();

        // Back-to-back: start held in the DONE cycle
        launch(MODE_ADD, 8'h03, 8'h04, 1'b0);
        wait_done(lat, busy_n);
        check_result("b2b_first", 8'h07, 1'b0, 1'b0, 1'b0);
        mode_in  = MODE_ADD;
        a_in     = 8'h01;
        b_in     = 8'h01;
        c_in     = 1'b0;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("b2b_rerun_busy", busy_out, 1);
        chk("b2b_rerun_done", done_out, 0);
        step();
        chk("b2b_partial0", sum_out, 8'h06);
        step();
        chk("b2b_partial1", sum_out, 8'h02);
        wait_done(lat, busy_n);
        chk("b2b_lat_rest", lat, 2);
        check_result("b2b", 8'h02, 1'b0, 1'b0, 1'b0);
        step();
        chk("b2b_pulse_end", done_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0 and CHUNK <= WIDTH SHALL be required, with elaboration failing otherwise.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk_in  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start_in  input  1  request; sampled on rising edge while idle or done.
REQ-006 The block SHALL have port mode_in  input  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 INC.
REQ-007 The block SHALL have ports a_in and b_in  input  WIDTH  operands.
REQ-008 The block SHALL have port c_in  input  1  carry for ADC.
REQ-009 The block SHALL have port busy_out  output  1  high while chunks are being processed.
REQ-010 The block SHALL have port done_out  output  1  one-cycle pulse marking valid results.
REQ-011 The block SHALL have port sum_out  output  WIDTH  result.
REQ-012 The block SHALL have ports c_out, v_out and z_out  output  1 each  carry-out, signed overflow and zero flag.

Function
REQ-013 The block SHALL use states IDLE, RUN and DONE; N = WIDTH/CHUNK.
REQ-014 When start_in is sampled high in IDLE or DONE, the block SHALL latch a_in, the effective B and the initial carry, clear the chunk index, and enter RUN.
- ADD: B = b_in, carry 0.
- ADC: B = b_in, carry c_in.
- SUB: B = ~b_in, carry 1.
- INC: B = 0, carry 1.
REQ-015 At each edge in RUN, the block SHALL add chunk idx using a CHUNK-bit lookahead adder, store the CHUNK sum bits into sum_out[idx*CHUNK +: CHUNK], register the chunk carry-out as the next carry, and increment idx.
REQ-016 At the edge where idx == N-1, the block SHALL go to DONE, latch c_out as the final carry, latch v_out = carry into MSB XOR final carry, and latch z_out = (full sum == 0).
REQ-017 done_out SHALL be high for exactly the one cycle spent in DONE, so the latency is N edges from the accepting edge to done_out high.
REQ-018 busy_out SHALL be high exactly while in RUN.
REQ-019 start_in SHALL be ignored in RUN; operand changes during RUN SHALL NOT affect the result.
REQ-020 From DONE, the block SHALL go to IDLE on the next edge unless start_in is high, in which case it goes to RUN for back-to-back operation.
REQ-021 sum_out and the flags SHALL hold their last values in IDLE and during the next RUN until overwritten.
REQ-022 sum_out chunks already written SHALL remain visible during RUN; only the DONE-cycle values are architecturally valid.
REQ-023 When CHUNK == WIDTH, the block SHALL behave as N=1, with done_out one edge after start.
REQ-024 The index counter width SHALL be max(1, $clog2(N)), and the index SHALL never exceed N-1.

Reset
REQ-025 When rst_n_in is low, the block SHALL immediately enter IDLE and clear busy_out, done_out, sum_out, c_out, v_out, z_out, the index and all latched operands to 0, regardless of clock.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation with no done_out pulse, and the first start after deassertion SHALL run normally.

Structure
REQ-027 The mode encoding enum and the state enum SHALL be defined in a shared package (chunked_adder_pkg) and used by the RTL and the bench.
REQ-028 The per-chunk adder SHALL be the existing FastAdder sub-module instantiated with BITS=CHUNK, with c_in tied to the carry register; no other sub-module SHALL be used.

Verification (WIDTH=8, CHUNK=2, N=4)
REQ-029 The bench SHALL check: ADD 0x7F+0x01 -> at the 4th edge after start, done_out=1, sum_out=0x80, c_out=0, v_out=1, z_out=0; busy_out high for 4 cycles.
REQ-030 The bench SHALL check: SUB 0x05-0x05 -> sum_out=0x00, c_out=1, v_out=0, z_out=1.
REQ-031 The bench SHALL check: ADC 0xFF+0x00 with c_in=1 -> sum_out=0x00, c_out=1, z_out=1, with the carry rippling through all 4 chunks.
REQ-032 The bench SHALL check: start ADD 0x10+0x20, then pulse start_in with changed operands during RUN -> the second start is ignored and the result is 0x30.
REQ-033 The bench SHALL check: assert rst_n_in low 2 edges into RUN -> all outputs 0 immediately with no done_out pulse; then INC 0xFF -> sum_out=0x00, c_out=1, z_out=1.
REQ-034 The bench SHALL check: start_in held high in the DONE cycle with ADD 0x01+0x01 -> RUN re-entered immediately and the next done_out is 4 edges later with sum_out=0x02.
